// File: rtl/frogger_game_state_if.sv
// frogger_game_state_if: bundle between the game-state controller and its environment (start/collided/frogger_y in, respawn/frog_enable/lives/score/game_over/state out)
interface frogger_game_state_if #(parameter int SCORE_WIDTH = 8);
  logic start;
  logic collided;
  logic [5:0] frogger_y;
  logic respawn;
  logic frog_enable;
  logic [2:0] lives;
  logic [SCORE_WIDTH-1:0] score;
  logic game_over;
  logic [1:0] state;
  modport master (output start, collided, frogger_y, input respawn, frog_enable, lives, score, game_over, state);
  modport slave (input start, collided, frogger_y, output respawn, frog_enable, lives, score, game_over, state);
endinterface

// File: rtl/frogger_game_state.sv
// frogger_game_state: lives/score/respawn/game-over controller; ports clk, rst (async high), ifc slave (start, collided, frogger_y in; respawn, frog_enable, lives, score, game_over, state out)
module frogger_game_state #(
  parameter int START_LIVES = 3,
  parameter int RESPAWN_TICKS = 12_500_000,
  parameter int GOAL_Y = 0,
  parameter int SCORE_WIDTH = 8
) (
  input logic clk,
  input logic rst,
  frogger_game_state_if.slave ifc
);
  localparam int TW = RESPAWN_TICKS > 1 ? $clog2(RESPAWN_TICKS) : 1;
  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DYING = 2'd2, OVER = 2'd3} state_t;
  state_t st;
  logic [TW-1:0] timer;
  logic coll_prev, respawn, frog_enable, game_over;
  logic [2:0] lives;
  logic [SCORE_WIDTH-1:0] score;
  logic coll_evt, goal;
  assign coll_evt = ifc.collided & ~coll_prev;
  // respawn high means the mover has not yet reloaded Y, so the goal row reading is stale
  assign goal = ifc.frogger_y == 6'(GOAL_Y) && !respawn;
  assign ifc.respawn = respawn;
  assign ifc.frog_enable = frog_enable;
  assign ifc.lives = lives;
  assign ifc.score = score;
  assign ifc.game_over = game_over;
  assign ifc.state = st;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      timer <= '0;
      coll_prev <= 1'b0;
      respawn <= 1'b0;
      frog_enable <= 1'b0;
      game_over <= 1'b0;
      lives <= 3'(START_LIVES);
      score <= '0;
    end else begin
      coll_prev <= ifc.collided;
      respawn <= 1'b0;
      case (st)
        IDLE, OVER:
          if (ifc.start) begin
            st <= PLAY;
            frog_enable <= 1'b1;
            game_over <= 1'b0;
            respawn <= 1'b1;
            lives <= 3'(START_LIVES);
            score <= '0;
          end
        PLAY:
          if (coll_evt) begin
            st <= DYING;
            frog_enable <= 1'b0;
            lives <= lives != 3'd0 ? lives - 3'd1 : 3'd0;
            timer <= TW'(RESPAWN_TICKS - 1);
          end else if (goal) begin
            score <= &score ? score : score + 1'b1;
            respawn <= 1'b1;
          end
        DYING:
          if (timer != '0) timer <= timer - 1'b1;
          else if (lives == 3'd0) begin
            st <= OVER;
            game_over <= 1'b1;
          end else begin
            st <= PLAY;
            frog_enable <= 1'b1;
            respawn <= 1'b1;
          end
        default: begin
          st <= IDLE;
          frog_enable <= 1'b0;
          game_over <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_frogger_game_state.sv
// tb_frogger_game_state: directed self-checking bench for frogger_game_state
module tb_frogger_game_state;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  frogger_game_state_if #(.SCORE_WIDTH(8)) ifc ();
  frogger_game_state #(.START_LIVES(3), .RESPAWN_TICKS(4), .GOAL_Y(0), .SCORE_WIDTH(8)) dut (
    .clk(clk),
    .rst(rst),
    .ifc(ifc.slave)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    ifc.start = 0; ifc.collided = 0; ifc.frogger_y = 6'd20;
    rst = 1;
    step(); step();
    checks++; if (ifc.state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", ifc.state); end
    checks++; if (ifc.lives !== 3'd3) begin failures++; $display("FAIL reset_lives got=%0d exp=3", ifc.lives); end
    checks++; if (ifc.score !== 8'd0) begin failures++; $display("FAIL reset_score got=%0d exp=0", ifc.score); end
    checks++; if ({ifc.respawn, ifc.frog_enable, ifc.game_over} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ifc.respawn, ifc.frog_enable, ifc.game_over}); end
    rst = 0;
    step();
    checks++; if (ifc.state !== 2'd0) begin failures++; $display("FAIL idle_hold got=%0d exp=0", ifc.state); end
  endtask
  task automatic test_start();
    ifc.start = 1; step(); ifc.start = 0;
    checks++; if (ifc.state !== 2'd1) begin failures++; $display("FAIL start_state got=%0d exp=1", ifc.state); end
    checks++; if (ifc.respawn !== 1'b1) begin failures++; $display("FAIL start_respawn got=%b exp=1", ifc.respawn); end
    checks++; if (ifc.lives !== 3'd3 || ifc.score !== 8'd0) begin failures++; $display("FAIL start_lives_score got=%0d/%0d exp=3/0", ifc.lives, ifc.score); end
    checks++; if (ifc.frog_enable !== 1'b1) begin failures++; $display("FAIL start_enable got=%b exp=1", ifc.frog_enable); end
    step();
    checks++; if (ifc.respawn !== 1'b0) begin failures++; $display("FAIL start_respawn_one got=%b exp=0", ifc.respawn); end
  endtask
  task automatic test_collision_hold();
    ifc.collided = 1; step();
    checks++; if (ifc.state !== 2'd2 || ifc.lives !== 3'd2) begin failures++; $display("FAIL hold_enter got=%0d/%0d exp=2/2", ifc.state, ifc.lives); end
    checks++; if (ifc.frog_enable !== 1'b0) begin failures++; $display("FAIL hold_enable got=%b exp=0", ifc.frog_enable); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (ifc.state !== 2'd2) begin failures++; $display("FAIL hold_dying%0d got=%0d exp=2", i, ifc.state); end
    end
    step();
    checks++; if (ifc.state !== 2'd1 || ifc.respawn !== 1'b1) begin failures++; $display("FAIL hold_exit got=%0d/%b exp=1/1", ifc.state, ifc.respawn); end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (ifc.state !== 2'd1 || ifc.lives !== 3'd2 || ifc.respawn !== 1'b0) begin failures++; $display("FAIL hold_level%0d got=%0d/%0d/%b exp=1/2/0", i, ifc.state, ifc.lives, ifc.respawn); end
    end
    ifc.collided = 0; step();
  endtask
  task automatic collide(input logic [2:0] exp_lives, input logic [1:0] exp_state);
    ifc.collided = 1; step(); ifc.collided = 0;
    checks++; if (ifc.lives !== exp_lives || ifc.state !== 2'd2) begin failures++; $display("FAIL collide_enter got=%0d/%0d exp=%0d/2", ifc.lives, ifc.state, exp_lives); end
    repeat (4) step();
    checks++; if (ifc.state !== exp_state) begin failures++; $display("FAIL collide_exit got=%0d exp=%0d", ifc.state, exp_state); end
    step();
  endtask
  task automatic test_game_over();
    collide(3'd1, 2'd1);
    collide(3'd0, 2'd3);
    checks++; if (ifc.game_over !== 1'b1 || ifc.lives !== 3'd0 || ifc.frog_enable !== 1'b0) begin failures++; $display("FAIL over_flags got=%b/%0d/%b exp=1/0/0", ifc.game_over, ifc.lives, ifc.frog_enable); end
    ifc.start = 1; step(); ifc.start = 0;
    checks++; if (ifc.state !== 2'd1 || ifc.lives !== 3'd3 || ifc.score !== 8'd0 || ifc.respawn !== 1'b1 || ifc.game_over !== 1'b0) begin failures++; $display("FAIL restart got=%0d/%0d/%0d/%b/%b exp=1/3/0/1/0", ifc.state, ifc.lives, ifc.score, ifc.respawn, ifc.game_over); end
    step();
  endtask
  task automatic test_goal();
    ifc.frogger_y = 6'd0; step();
    checks++; if (ifc.score !== 8'd1 || ifc.respawn !== 1'b1) begin failures++; $display("FAIL goal_first got=%0d/%b exp=1/1", ifc.score, ifc.respawn); end
    ifc.frogger_y = 6'd20; step();
    checks++; if (ifc.score !== 8'd1 || ifc.respawn !== 1'b0) begin failures++; $display("FAIL goal_single got=%0d/%b exp=1/0", ifc.score, ifc.respawn); end
    step();
    checks++; if (ifc.score !== 8'd1) begin failures++; $display("FAIL goal_stable got=%0d exp=1", ifc.score); end
    ifc.frogger_y = 6'd0; step();
    checks++; if (ifc.score !== 8'd2) begin failures++; $display("FAIL goal_held1 got=%0d exp=2", ifc.score); end
    step();
    checks++; if (ifc.score !== 8'd2 || ifc.respawn !== 1'b0) begin failures++; $display("FAIL goal_masked got=%0d/%b exp=2/0", ifc.score, ifc.respawn); end
    step();
    checks++; if (ifc.score !== 8'd3) begin failures++; $display("FAIL goal_held3 got=%0d exp=3", ifc.score); end
    ifc.frogger_y = 6'd20; step();
  endtask
  task automatic test_priority();
    ifc.collided = 1; ifc.frogger_y = 6'd0; step();
    ifc.collided = 0; ifc.frogger_y = 6'd20;
    checks++; if (ifc.state !== 2'd2 || ifc.lives !== 3'd2 || ifc.score !== 8'd3) begin failures++; $display("FAIL priority got=%0d/%0d/%0d exp=2/2/3", ifc.state, ifc.lives, ifc.score); end
    repeat (4) step();
    checks++; if (ifc.state !== 2'd1) begin failures++; $display("FAIL priority_back got=%0d exp=1", ifc.state); end
    step();
  endtask
  task automatic test_async_reset();
    ifc.collided = 1; step(); ifc.collided = 0; step();
    checks++; if (ifc.state !== 2'd2) begin failures++; $display("FAIL arst_pre got=%0d exp=2", ifc.state); end
    #2 rst = 1;
    #1;
    checks++; if (ifc.state !== 2'd0 || ifc.lives !== 3'd3 || ifc.score !== 8'd0) begin failures++; $display("FAIL arst_vals got=%0d/%0d/%0d exp=0/3/0", ifc.state, ifc.lives, ifc.score); end
    checks++; if ({ifc.respawn, ifc.frog_enable, ifc.game_over} !== 3'b000) begin failures++; $display("FAIL arst_flags got=%b exp=000", {ifc.respawn, ifc.frog_enable, ifc.game_over}); end
    step(); rst = 0; step(); step();
    checks++; if (ifc.state !== 2'd0 || ifc.respawn !== 1'b0) begin failures++; $display("FAIL arst_idle got=%0d/%b exp=0/0", ifc.state, ifc.respawn); end
  endtask
  task automatic test_score_saturation();
    ifc.start = 1; step(); ifc.start = 0; step();
    ifc.frogger_y = 6'd0;
    repeat (520) step();
    checks++; if (ifc.score !== 8'd255) begin failures++; $display("FAIL sat_reach got=%0d exp=255", ifc.score); end
    repeat (4) step();
    checks++; if (ifc.score !== 8'd255 || ifc.state !== 2'd1) begin failures++; $display("FAIL sat_hold got=%0d/%0d exp=255/1", ifc.score, ifc.state); end
    ifc.frogger_y = 6'd20; step();
  endtask
  initial begin
    test_reset();
    test_start();
    test_collision_hold();
    test_game_over();
    test_goal();
    test_priority();
    test_async_reset();
    test_score_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
